// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data_mem arbiter.
// Holds the FSM encoding, requester port IDs and the latched command payload.
package data_mem_arb_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned MASK_W          = 4;
   localparam int unsigned DEFAULT_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   // Per-transaction attributes latched at grant time (address kept separately, it is parameterised).
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] sign_mask;
   } mem_cmd_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-input picker: returns the port ID that wins this IDLE cycle.
// Ties go to cpu under fixed priority, otherwise to the port not granted last.
module rr_arb2
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       fixed_prio_i,
   output logic       grant_c_o
);

   always_comb begin
      grant_c_o = PORT_CPU;
      case (req_i)
         2'b10:   grant_c_o = PORT_AUX;
         2'b11:   grant_c_o = fixed_prio_i ? PORT_CPU : ~last_i;
         default: grant_c_o = PORT_CPU;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data_mem port between cpu and aux requesters, translating req/ack into
// data_mem's one-cycle strobe / clk_stall completion protocol with a WAIT timeout.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_sign_mask,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [31:0]       aux_wdata,
   input  logic [3:0]        aux_sign_mask,
   output logic              aux_ack,
   output logic [31:0]       aux_rdata,
   output logic              aux_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   output logic [3:0]        mem_sign_mask,
   output logic              mem_memread,
   output logic              mem_memwrite,
   input  logic [31:0]       mem_read_data,
   input  logic              mem_clk_stall,
   output logic              busy,
   output logic              grant_aux
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic              seen_stall_q, seen_stall_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              memread_q, memread_d;
   logic              memwrite_q, memwrite_d;
   logic              grant_aux_q, grant_aux_d;
   logic              busy_q, busy_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              cpu_err_q, cpu_err_d;
   logic              aux_ack_q, aux_ack_d;
   logic [31:0]       aux_rdata_q, aux_rdata_d;
   logic              aux_err_q, aux_err_d;

   logic              win_c;
   logic [CNT_W-1:0]  cnt_inc;
   logic              done;
   logic [31:0]       rsp_data;
   logic              rsp_err;

   rr_arb2 u_pick (
      .req_i        ({aux_req, cpu_req}),
      .last_i       (last_q),
      .fixed_prio_i (FIXED_PRIO),
      .grant_c_o    (win_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= PORT_AUX;
         seen_stall_q <= 1'b0;
         cnt_q        <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         grant_aux_q  <= 1'b0;
         busy_q       <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_err_q    <= 1'b0;
         aux_ack_q    <= 1'b0;
         aux_rdata_q  <= '0;
         aux_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         seen_stall_q <= seen_stall_d;
         cnt_q        <= cnt_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         memread_q    <= memread_d;
         memwrite_q   <= memwrite_d;
         grant_aux_q  <= grant_aux_d;
         busy_q       <= busy_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_err_q    <= cpu_err_d;
         aux_ack_q    <= aux_ack_d;
         aux_rdata_q  <= aux_rdata_d;
         aux_err_q    <= aux_err_d;
      end
   end

   // Strobes and acks default low so each is a single registered pulse.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      seen_stall_d = seen_stall_q;
      cnt_d        = cnt_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      memread_d    = 1'b0;
      memwrite_d   = 1'b0;
      grant_aux_d  = grant_aux_q;
      cpu_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      cpu_err_d    = cpu_err_q;
      aux_ack_d    = 1'b0;
      aux_rdata_d  = aux_rdata_q;
      aux_err_d    = aux_err_q;
      cnt_inc      = cnt_q + CNT_W'(1);
      done         = 1'b0;
      rsp_data     = '0;
      rsp_err      = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req || aux_req) begin
               grant_aux_d = win_c;
               if (win_c == PORT_AUX) begin
                  cmd_d  = '{we: aux_we, wdata: aux_wdata, sign_mask: aux_sign_mask};
                  addr_d = aux_addr;
               end else begin
                  cmd_d  = '{we: cpu_we, wdata: cpu_wdata, sign_mask: cpu_sign_mask};
                  addr_d = cpu_addr;
               end
               // Strobe registered on ISSUE entry so it is high for exactly the ISSUE cycle.
               memread_d  = ~cmd_d.we;
               memwrite_d = cmd_d.we;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d        = '0;
            seen_stall_d = 1'b0;
            state_d      = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (mem_clk_stall) begin
               seen_stall_d = 1'b1;
            end
            // Real completion wins over a timeout landing in the same cycle.
            if (!mem_clk_stall && seen_stall_q) begin
               done     = 1'b1;
               rsp_data = cmd_q.we ? 32'h0 : mem_read_data;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               done    = 1'b1;
               rsp_err = 1'b1;
            end
            if (done) begin
               state_d = RESP;
               if (grant_aux_q) begin
                  aux_ack_d   = 1'b1;
                  aux_rdata_d = rsp_data;
                  aux_err_d   = rsp_err;
               end else begin
                  cpu_ack_d   = 1'b1;
                  cpu_rdata_d = rsp_data;
                  cpu_err_d   = rsp_err;
               end
            end
         end
         RESP: begin
            last_d  = grant_aux_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign cpu_ack        = cpu_ack_q;
   assign cpu_rdata      = cpu_rdata_q;
   assign cpu_err        = cpu_err_q;
   assign aux_ack        = aux_ack_q;
   assign aux_rdata      = aux_rdata_q;
   assign aux_err        = aux_err_q;
   assign mem_addr       = addr_q;
   assign mem_write_data = cmd_q.wdata;
   assign mem_sign_mask  = cmd_q.sign_mask;
   assign mem_memread    = memread_q;
   assign mem_memwrite   = memwrite_q;
   assign busy           = busy_q;
   assign grant_aux      = grant_aux_q;

endmodule
